sha_auth_loader: RTL and testbench

SHA_AUTH_LOADER -- requirements
Module: sha_auth_loader

---
 rtl/sha_auth_loader_if.sv | 23 ++
 rtl/sha_auth_loader.sv | 156 +++++++++++++++
 tb/tb_sha_auth_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_auth_loader_if.sv
// Loader-side word stream and authenticator register bus.
// slave = loader, master = stream source / authenticator side.
interface sha_auth_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        cs;
  logic        we;
  logic        wc;
  logic [2:0]  address;
  logic [31:0] write_data;
  logic        digest_valid;

  modport slave (
    input  in_valid, in_data, digest_valid,
    output in_ready, cs, we, wc, address, write_data
  );

  modport master (
    output in_valid, in_data, digest_valid,
    input  in_ready, cs, we, wc, address, write_data
  );
endinterface

// File: rtl/sha_auth_loader.sv
// Streams 8 block words and 8 digest words into an authenticator,
// strobes init, then waits (bounded) for the digest match flag.
module sha_auth_loader #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  sha_auth_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic auth_pass,
  output logic auth_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BLK,
    S_LOAD_DIG,
    S_INIT,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  timer_q, timer_d;
  logic        rdy_q, rdy_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic        wc_q, wc_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        acc;

  assign acc = bus.in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    wc_d    = wc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD_BLK;
            cnt_d   = 4'd0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
          end
        end
        S_LOAD_BLK, S_LOAD_DIG: begin
          if (acc) begin
            we_d    = 1'b1;
            wc_d    = ~cnt_q[3];
            addr_d  = cnt_q[2:0];
            wdata_d = bus.in_data;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7)
              state_d = S_LOAD_DIG;
            else if (cnt_q == 4'd15)
              state_d = S_INIT;
          end
        end
        // This cycle carries the final digest write; cs follows it.
        S_INIT: begin
          cs_d    = 1'b1;
          timer_d = 8'd0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.digest_valid) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
            done_d  = 1'b1;
          end else if (timer_q == TLAST) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    rdy_d  = (state_d == S_LOAD_BLK) ||
             (state_d == S_LOAD_DIG);
    busy_d = rdy_d ||
             (state_d == S_INIT) ||
             (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      timer_q <= 8'd0;
      rdy_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      wc_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      rdy_q   <= rdy_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.cs         = cs_q;
  assign bus.we         = we_q;
  assign bus.wc         = wc_q;
  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign auth_pass      = pass_q;
  assign auth_fail      = fail_q;

endmodule

// File: tb/tb_sha_auth_loader.sv
// Scoreboard bench: driver queues expected writes/results per run,
// a negedge monitor pops and compares whenever the DUT shows we or done.
module tb_sha_auth_loader;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, auth_pass, auth_fail;

  sha_auth_loader_if bus();

  sha_auth_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .bus(bus),
    .busy(busy),
    .done(done),
    .auth_pass(auth_pass),
    .auth_fail(auth_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wc;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic pass;
    int   lat;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  initial begin
    bit prev_last = 0;
    bit prev_done = 0;
    int cs_cyc = 0;
    wr_t w;
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_last = 0;
        prev_done = 0;
        cs_cyc = 0;
      end else begin
        if (bus.we) begin
          if (wr_q.size() == 0) chk("we_unexpected", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("wr_wc", bus.wc, w.wc);
            chk("wr_addr", bus.address, w.addr);
            chk("wr_data", bus.write_data, w.data);
          end
        end
        if (bus.cs) begin
          chk("cs_after_last_we", prev_last, 1);
          chk("cs_we_excl", bus.we, 0);
          cs_cyc = cyc;
        end
        if (done) begin
          chk("done_one_cycle", prev_done, 0);
          if (res_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            r = res_q.pop_front();
            chk("auth_pass", auth_pass, r.pass);
            chk("auth_fail", auth_fail, !r.pass);
            chk("done_busy", busy, 0);
            chk("done_latency", cyc - cs_cyc, r.lat);
          end
        end
        if (auth_pass && auth_fail) chk("pass_fail_excl", 1, 0);
        prev_last = bus.we && bus.address == 3'd7 && !bus.wc;
        prev_done = done;
      end
    end
  end

  task automatic load(input int mode, input int ab, output bit aborted);
    logic [31:0] w[16];
    int idx, n, g;
    bit v, pend;
    aborted = 0;
    idx = 0;
    n = 0;
    g = 0;
    for (int i = 0; i < 16; i++) begin
      w[i] = (mode == 2) ? $urandom : 32'h1000_0000 + i;
      wr_q.push_back('{wc: (i < 8), addr: 3'(i), data: w[i]});
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (idx < 16) begin
      if (idx == ab) begin
        abort = 1;
        bus.in_valid = 0;
        @(posedge clk);
        #1;
        abort = 0;
        chk("abort_we", bus.we, 0);
        chk("abort_rdy", bus.in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cs", bus.cs, 0);
        wr_q.delete();
        res_q.delete();
        aborted = 1;
        @(negedge clk);
        return;
      end
      case (mode)
        0: v = 1;
        1: v = (n % 4 == 0) || (n % 4 == 3);
        default: v = $urandom_range(0, 1) == 1;
      endcase
      bus.in_valid = v;
      bus.in_data = w[idx];
      start = (mode == 2) && ($urandom_range(0, 3) == 0);
      pend = v && bus.in_ready;
      @(negedge clk);
      if (pend) idx++;
      n++;
      g++;
      if (g > 2000) begin
        chk("load_timeout", idx, 16);
        break;
      end
    end
    bus.in_valid = 0;
    start = 0;
  endtask

  task automatic wait_cs();
    int g = 0;
    while (!bus.cs && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("cs_seen", bus.cs, 1);
  endtask

  task automatic digest(input int k);
    int g = 0;
    int j = 0;
    wait_cs();
    while (!done && g < 400) begin
      bus.digest_valid = (j >= k);
      @(negedge clk);
      j++;
      g++;
    end
    chk("done_seen", done, 1);
    bus.digest_valid = 0;
  endtask

  task automatic run(input int mode, input int k, input int ab);
    bit aborted;
    res_q.push_back('{pass: (k < TMO), lat: (k < TMO) ? k + 1 : TMO});
    load(mode, ab, aborted);
    if (!aborted) digest(k);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ab;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.digest_valid = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", auth_pass, 0);
    chk("rst_fail", auth_fail, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_cs", bus.cs, 0);
    chk("rst_wc", bus.wc, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_wdata", bus.write_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);

    run(0, 66, -1);
    run(0, 1000, -1);
    run(1, 0, -1);
    run(0, TMO - 1, -1);
    run(0, TMO, -1);
    run(2, 7, 10);
    run(2, 5, -1);

    load(0, -1, ab);
    wait_cs();
    repeat (30) @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cs", bus.cs, 0);
    chk("arst_we", bus.we, 0);
    chk("arst_rdy", bus.in_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", auth_pass, 0);
    chk("arst_fail", auth_fail, 0);
    chk("arst_addr", bus.address, 0);
    chk("arst_wdata", bus.write_data, 0);
    wr_q.delete();
    res_q.delete();
    @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_cs", bus.cs, 0);
    run(0, 66, -1);

    for (int i = 0; i < 8; i++)
      run($urandom_range(1, 2), $urandom_range(0, 120), -1);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
